// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the N-way write-back cache.
// No logic; no latency; no backpressure.
// Widths derive from SETS, ADDR_W and WAYS so every file agrees.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2,
        ST_RESPOND   = 2'd3
    } state_t;

    function automatic int index_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int sets);
        return addr_w - 2 - $clog2(sets);
    endfunction

    function automatic int age_width(input int ways);
        return $clog2(ways);
    endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age array, one age per way per set (0 = most recently used).
// Update lands on the clock edge of the access strobe; lru_way is combinational.
// No backpressure: an access is applied whenever acc_en is high.
module cache_lru
    import cache_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 256,
    localparam int IW = index_width(SETS),
    localparam int AW = age_width(WAYS)
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic [IW-1:0] set_idx,
    input  logic [AW-1:0] acc_way,
    input  logic          acc_en,
    output logic [AW-1:0] lru_way
);

    logic [AW-1:0] age_q [SETS][WAYS];

    // Ways younger than the accessed one age by one; the rest keep their age.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= AW'(w);
        end else if (acc_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AW'(w) == acc_way)
                    age_q[set_idx][w] <= '0;
                else if (age_q[set_idx][w] < age_q[set_idx][acc_way])
                    age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
            end
        end
    end

    always_comb begin
        lru_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (age_q[set_idx][w] == AW'(WAYS - 1))
                lru_way = AW'(w);
    end

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back/write-allocate cache, true-LRU, blocking misses; CACHE_STATS_EN adds hit/miss/writeback counters.
// Hit: rc_Done one cycle after acceptance. Miss: 1 + writeback handshake + refill handshake + 1.
// rc_Ready drops outside IDLE; memory requests are held stable until their Ready.
module cache_nway_wb
    import cache_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int SETS   = 256,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              rc_Valid,
    input  logic              rc_RW,
    input  logic [ADDR_W-1:0] rc_Addr,
    input  logic [DATA_W-1:0] rc_WriteData,
    output logic              rc_Ready,
    output logic              rc_Done,
    output logic [DATA_W-1:0] rc_ReadData,
    output logic              cm_ReadValid,
    output logic [ADDR_W-1:0] cm_ReadAddr,
    input  logic              cm_ReadReady,
    input  logic [DATA_W-1:0] cm_ReadData,
    output logic              cm_WriteValid,
    output logic [ADDR_W-1:0] cm_WriteAddr,
    output logic [DATA_W-1:0] cm_WriteData,
    input  logic              cm_WriteReady
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       stat_Hits,
    output logic [31:0]       stat_Misses,
    output logic [31:0]       stat_Writebacks
`endif
);

    localparam int IW = index_width(SETS);
    localparam int TW = tag_width(ADDR_W, SETS);
    localparam int AW = age_width(WAYS);

    state_t state_q, state_d;

    logic              req_rw_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [AW-1:0]     victim_q;
    logic              hit_done_q;
    logic [DATA_W-1:0] rdata_q;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [TW-1:0]     tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];

    // Outside IDLE the set/tag come from the latched miss request.
    logic [ADDR_W-1:0] addr_cur;
    logic [IW-1:0]     idx;
    logic [TW-1:0]     cur_tag;
    logic              addr_unused;

    assign addr_cur    = (state_q == ST_IDLE) ? rc_Addr : req_addr_q;
    assign idx         = addr_cur[2+IW-1:2];
    assign cur_tag     = addr_cur[ADDR_W-1:2+IW];
    assign addr_unused = ^addr_cur[1:0];

    logic          hit, inv_found;
    logic [AW-1:0] hit_way, inv_way, lru_way, victim;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == cur_tag) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = AW'(w);
            end
        end
    end

    assign victim = inv_found ? inv_way : lru_way;

    logic accept, hit_acc, miss_acc, wb_done, refill_done;
    assign accept      = rc_Ready && rc_Valid;
    assign hit_acc     = accept && hit;
    assign miss_acc    = accept && !hit;
    assign wb_done     = (state_q == ST_WRITEBACK) && cm_WriteReady;
    assign refill_done = (state_q == ST_REFILL) && cm_ReadReady;

    cache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
        .CLK     (CLK),
        .Reset   (Reset),
        .set_idx (idx),
        .acc_way (hit_acc ? hit_way : victim_q),
        .acc_en  (hit_acc || refill_done),
        .lru_way (lru_way)
    );

    always_ff @(posedge CLK) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (miss_acc)
                    state_d = (valid_q[idx][victim] && dirty_q[idx][victim]) ? ST_WRITEBACK : ST_REFILL;
            ST_WRITEBACK: if (wb_done)     state_d = ST_REFILL;
            ST_REFILL:    if (refill_done) state_d = ST_RESPOND;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rc_Ready      = (state_q == ST_IDLE) && Reset;
        rc_Done       = hit_done_q || (state_q == ST_RESPOND);
        rc_ReadData   = rdata_q;
        cm_ReadValid  = 1'b0;
        cm_ReadAddr   = '0;
        cm_WriteValid = 1'b0;
        cm_WriteAddr  = '0;
        cm_WriteData  = '0;
        case (state_q)
            ST_WRITEBACK: begin
                cm_WriteValid = 1'b1;
                cm_WriteAddr  = {tag_q[idx][victim_q], idx, 2'b00};
                cm_WriteData  = data_q[idx][victim_q];
            end
            ST_REFILL: begin
                cm_ReadValid = 1'b1;
                cm_ReadAddr  = {cur_tag, idx, 2'b00};
            end
            default: ;
        endcase
    end

    // rdata_q defaults to zero so write completions return 0.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
            req_rw_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            victim_q    <= '0;
            hit_done_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            hit_done_q <= hit_acc;
            rdata_q    <= '0;
            if (hit_acc) begin
                if (rc_RW) dirty_q[idx][hit_way] <= 1'b1;
                else       rdata_q <= data_q[idx][hit_way];
            end
            if (miss_acc) begin
                req_rw_q    <= rc_RW;
                req_addr_q  <= rc_Addr;
                req_wdata_q <= rc_WriteData;
                victim_q    <= victim;
            end
            if (refill_done) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= req_rw_q;
                if (!req_rw_q) rdata_q <= cm_ReadData;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            if (hit_acc && rc_RW)
                data_q[idx][hit_way] <= rc_WriteData;
            if (refill_done) begin
                tag_q[idx][victim_q]  <= cur_tag;
                data_q[idx][victim_q] <= req_rw_q ? req_wdata_q : cm_ReadData;
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            stat_Hits       <= '0;
            stat_Misses     <= '0;
            stat_Writebacks <= '0;
        end else begin
            if (hit_acc  && stat_Hits   != '1) stat_Hits   <= stat_Hits + 1'b1;
            if (miss_acc && stat_Misses != '1) stat_Misses <= stat_Misses + 1'b1;
            if (wb_done  && stat_Writebacks != '1) stat_Writebacks <= stat_Writebacks + 1'b1;
        end
    end
`endif

endmodule
